sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port packet-buffer SRAM (256 x 72) between three requesters: packet ingress writer (port 0), packet egress reader (port 1) and CPU register-access path (port 2).
- Sits between the FIFO datapath control and the SRAM macro.
- Round-robin arbitration, one access per cycle, read-return routing with a configurable SRAM read latency.
- Provides a saturating stall counter exported as a hardware register.

Parameters:
- ADDR_WIDTH, 8: SRAM address width.
- DATA_WIDTH, 72: SRAM word width (64 data + 8 ctrl).
- RD_LAT, 1: SRAM read latency in cycles, from sram_en to sram_rdata valid; legal range 1..3.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  3  per-port request; bit0 ingress, bit1 egress, bit2 cpu
- wen  in  3  per-port write enable, qualified by req
- addr  in  3*ADDR_WIDTH  per-port address; port i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  3*DATA_WIDTH  per-port write data; sliced the same way as addr
- gnt  out  3  one-hot grant; combinational from req and internal state
- rvalid  out  3  one-cycle read-return strobe for the owning port
- rdata  out  DATA_WIDTH  registered read data, shared by all ports
- cpu_lock  in  1  CPU exclusive-access request (see Optional Feature)
- stall_clr  in  1  synchronous clear of stall_cnt
- stall_cnt  out  32  cycles in which at least one request was not granted
- sram_en  out  1  SRAM access strobe (registered)
- sram_we  out  1  SRAM write enable (registered)
- sram_addr  out  ADDR_WIDTH  SRAM address (registered)
- sram_wdata  out  DATA_WIDTH  SRAM write data (registered)
- sram_rdata  in  DATA_WIDTH  SRAM read data

Behaviour:
- Reset values: gnt=0 (forced low while reset is high), rvalid=0, rdata=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, stall_cnt=0, state=ARB, last_gnt=2 (port 0 has highest priority first).
- Handshake: an access is accepted at a rising edge when req[i]&gnt[i]=1. The requester holds req, wen, addr and wdata stable until it is granted. Back-to-back grants to the same port are allowed.
- At most one gnt bit is high per cycle. gnt=0 when req=0.
- Round-robin: search order starts at last_gnt+1 mod 3. last_gnt updates only on an accepted access.
- Timing, for an access accepted at the end of cycle t:
  - sram_en, sram_we, sram_addr and sram_wdata are driven during cycle t+1.
  - sram_en=0 in any cycle following a cycle with no accepted access. sram_addr and sram_wdata hold their previous values then.
  - For a read, sram_rdata is sampled in cycle t+1+RD_LAT; rdata and rvalid[owner] are valid in cycle t+2+RD_LAT.
  - Reads are fully pipelined: one read per cycle yields one rvalid per cycle, in order.
- Writes produce no rvalid.
- rdata holds its value between rvalid pulses.
- Read tracking: shift register of depth RD_LAT+1 carrying {valid, owner[1:0]}.
- State machine: ARB (round-robin) and LOCKED (cpu only). Transitions are defined under Optional Feature. Without the macro, the state stays ARB.
- stall_cnt:
  - +1 on each cycle where (req & ~gnt) != 0.
  - Saturates at 32'hFFFF_FFFF.
  - stall_clr has priority over increment: the counter is 0 on the next cycle.
- Reset mid-operation: tracking shift register cleared, so no rvalid is emitted for reads issued before reset. Lock is released.
- wen on a non-granted port is ignored.

Optional Feature:
- Macro: SRAM_ARB_LOCK_EN.
- With the macro defined:
  - ARB->LOCKED when port 2 is granted while cpu_lock=1.
  - In LOCKED, gnt[0] and gnt[1] are forced 0, and gnt[2]=req[2].
  - LOCKED->ARB in the first cycle cpu_lock=0. Round-robin applies in that same cycle, with last_gnt=2.
  - Stalled requests on ports 0 and 1 count toward stall_cnt.
- Without the macro: cpu_lock is ignored and the state is always ARB. The port remains present.

Test Plan:
- Reset, then req=3'b111 held constant with all reads -> gnt sequence 001,010,100,001 over successive cycles; stall_cnt=1,2,3,4 at the end of each cycle.
- Port 1 read of addr 8'h05 accepted at cycle 10, RD_LAT=1, SRAM model returns 72'hAB_0123456789ABCDEF -> rvalid=3'b010 only in cycle 13, with rdata equal to that value; rdata held afterwards.
- Port 0 writes 72'h11 to addr 8'h20 (cycle 5), then port 2 reads 8'h20 (cycle 6) -> sram_we=1 in cycle 6; cpu rvalid in cycle 9 with rdata=72'h11.
- RD_LAT=3, port 1 issues four back-to-back reads -> four consecutive rvalid[1] pulses starting 5 cycles after the first accept, data in address order.
- Read accepted, then reset asserted for 1 cycle before its return -> no rvalid is ever asserted; stall_cnt=0; the next grant goes to port 0.
- SRAM_ARB_LOCK_EN defined, cpu_lock=1 and req=3'b111 -> gnt=100 for every cycle while locked and stall_cnt increments each cycle. Dropping cpu_lock -> gnt=001 in that same cycle.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares one single-port packet-buffer SRAM between three requesters:
//   port 0 = packet ingress writer, port 1 = packet egress reader, port 2 = CPU path.
// One access per cycle, round-robin priority, registered SRAM strobes, read data
// routed back to the issuing port after the SRAM read latency, plus a saturating
// stall counter.
//
// Optional feature: define SRAM_ARB_LOCK_EN to let the CPU (port 2) hold the SRAM
// exclusively while cpu_lock is high. Without it cpu_lock has no effect.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   req/wen/addr/wdata     per-port request, write enable, address, write data
//   gnt                    one-hot grant (combinational)
//   rvalid/rdata           one-cycle read-return strobe per port, shared read data
//   cpu_lock               CPU exclusive-access request
//   stall_clr/stall_cnt    clear / value of the stalled-cycle counter
//   sram_*                 registered SRAM macro interface, sram_rdata from macro

module sram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 72,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              req,
  input  logic [2:0]              wen,
  input  logic [3*ADDR_WIDTH-1:0] addr,
  input  logic [3*DATA_WIDTH-1:0] wdata,
  output logic [2:0]              gnt,
  output logic [2:0]              rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    cpu_lock,
  input  logic                    stall_clr,
  output logic [31:0]             stall_cnt,
  output logic                    sram_en,
  output logic                    sram_we,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  input  logic [DATA_WIDTH-1:0]   sram_rdata
);

  typedef enum logic [0:0] {StArb, StLocked} state_e;

  state_e state_q, state_d;
  logic [1:0] last_gnt_q;
  logic [2:0] gnt_rr;
  logic       lock_active;
  logic [1:0] gnt_idx;
  logic       accept;
  logic       sel_wen;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [31:0] stall_d;

  // Read tracking: stage k holds a read issued k+1 cycles ago; the last stage lines
  // up with valid sram_rdata.
  logic [RD_LAT:0]       trk_vld_q;
  logic [RD_LAT:0][1:0]  trk_own_q;

  // Round-robin: search starts at the port after the last accepted one.
  always_comb begin
    gnt_rr = 3'b000;
    case (last_gnt_q)
      2'd0: begin
        if      (req[1]) gnt_rr = 3'b010;
        else if (req[2]) gnt_rr = 3'b100;
        else if (req[0]) gnt_rr = 3'b001;
      end
      2'd1: begin
        if      (req[2]) gnt_rr = 3'b100;
        else if (req[0]) gnt_rr = 3'b001;
        else if (req[1]) gnt_rr = 3'b010;
      end
      default: begin
        if      (req[0]) gnt_rr = 3'b001;
        else if (req[1]) gnt_rr = 3'b010;
        else if (req[2]) gnt_rr = 3'b100;
      end
    endcase
  end

  // Once cpu_lock drops, round-robin takes over in that same cycle; last_gnt_q is
  // already 2 because only the CPU could be granted while locked.
  assign lock_active = (state_q == StLocked) && cpu_lock;

  always_comb begin
    state_d = state_q;
    gnt     = 3'b000;
    if (!reset) begin
      if (lock_active) gnt = {req[2], 2'b00};
      else             gnt = gnt_rr;
    end
`ifdef SRAM_ARB_LOCK_EN
    unique case (state_q)
      StArb:    if (gnt[2] && cpu_lock) state_d = StLocked;
      StLocked: if (!cpu_lock)          state_d = StArb;
    endcase
`else
    state_d = StArb;
`endif
  end

  assign accept = |gnt;

  always_comb begin
    gnt_idx = 2'd0;
    if (gnt[1]) gnt_idx = 2'd1;
    if (gnt[2]) gnt_idx = 2'd2;
  end

  always_comb begin
    sel_wen   = wen[0];
    sel_addr  = addr[0 +: ADDR_WIDTH];
    sel_wdata = wdata[0 +: DATA_WIDTH];
    unique case (gnt_idx)
      2'd1: begin
        sel_wen   = wen[1];
        sel_addr  = addr[ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata[DATA_WIDTH +: DATA_WIDTH];
      end
      2'd2: begin
        sel_wen   = wen[2];
        sel_addr  = addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata[2*DATA_WIDTH +: DATA_WIDTH];
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_d = stall_cnt;
    if (stall_clr) begin
      stall_d = '0;
    end else if (((req & ~gnt) != 3'b000) && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_d = stall_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StArb;
      last_gnt_q <= 2'd2;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      trk_vld_q  <= '0;
      trk_own_q  <= '0;
      rvalid     <= 3'b000;
      rdata      <= '0;
      stall_cnt  <= '0;
    end else begin
      state_q <= state_d;
      sram_en <= accept;
      sram_we <= accept & sel_wen;
      if (accept) begin
        last_gnt_q <= gnt_idx;
        sram_addr  <= sel_addr;
        sram_wdata <= sel_wdata;
      end
      trk_vld_q <= {trk_vld_q[RD_LAT-1:0], accept & ~sel_wen};
      trk_own_q <= {trk_own_q[RD_LAT-1:0], gnt_idx};
      rvalid    <= trk_vld_q[RD_LAT] ? (3'b001 << trk_own_q[RD_LAT]) : 3'b000;
      if (trk_vld_q[RD_LAT]) rdata <= sram_rdata;
      stall_cnt <= stall_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: two instances (read latency 1 and 3) share one
// stimulus stream; each has its own behavioural SRAM. A transaction-level model
// predicts grants, SRAM strobes, read returns and the stall counter.

module tb_sram_port_arbiter;

  localparam int AW     = 8;
  localparam int DW     = 72;
  localparam int MaxCyc = 8192;

  typedef struct {
    int              due;
    logic [1:0]      own;
    logic [DW-1:0]   dat;
  } rd_t;

  logic            clk = 1'b0;
  logic            reset, cpu_lock, stall_clr, fill;
  logic [2:0]      req, wen;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;

  logic [2:0]    gnt_a [2];
  logic [2:0]    rvalid_a [2];
  logic [DW-1:0] rdata_a [2];
  logic [31:0]   stall_a [2];
  logic          sram_en_a [2];
  logic          sram_we_a [2];
  logic [AW-1:0] sram_addr_a [2];
  logic [DW-1:0] sram_wdata_a [2];
  logic [DW-1:0] sram_rdata_a [2];

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset(reset), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
    .gnt(gnt_a[0]), .rvalid(rvalid_a[0]), .rdata(rdata_a[0]), .cpu_lock(cpu_lock),
    .stall_clr(stall_clr), .stall_cnt(stall_a[0]), .sram_en(sram_en_a[0]),
    .sram_we(sram_we_a[0]), .sram_addr(sram_addr_a[0]), .sram_wdata(sram_wdata_a[0]),
    .sram_rdata(sram_rdata_a[0])
  );

  sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(3)) u_dut_lat3 (
    .clk(clk), .reset(reset), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
    .gnt(gnt_a[1]), .rvalid(rvalid_a[1]), .rdata(rdata_a[1]), .cpu_lock(cpu_lock),
    .stall_clr(stall_clr), .stall_cnt(stall_a[1]), .sram_en(sram_en_a[1]),
    .sram_we(sram_we_a[1]), .sram_addr(sram_addr_a[1]), .sram_wdata(sram_wdata_a[1]),
    .sram_rdata(sram_rdata_a[1])
  );

  function automatic logic [DW-1:0] seed_word(int a);
    return {8'(a ^ 8'h5A), 64'(a) * 64'h9E37_79B9_7F4A_7C15};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    return DW'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Behavioural SRAMs; unread cycles push junk so mistimed sampling is visible.
  logic [DW-1:0] mem [2][256];
  logic [DW-1:0] pipe [2][3];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (fill) begin
        for (int i = 0; i < 256; i++) mem[d][i] <= seed_word(i);
      end else if (sram_en_a[d] && sram_we_a[d]) begin
        mem[d][sram_addr_a[d]] <= sram_wdata_a[d];
      end
      pipe[d][0] <= (sram_en_a[d] && !sram_we_a[d]) ? mem[d][sram_addr_a[d]] : rand_word();
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end

  assign sram_rdata_a[0] = pipe[0][0];
  assign sram_rdata_a[1] = pipe[1][2];

  // Reference model state.
  int            n_vec, n_err, cyc, m_last;
  bit            m_locked;
  logic [31:0]   m_stall;
  logic [2:0]    m_gnt, obs_gnt;
  logic          e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [DW-1:0] e_rdata [2];
  logic [DW-1:0] ref_mem [256];
  rd_t           rq0[$], rq1[$];
  logic [2:0]    h_rv [2][MaxCyc];
  logic [DW-1:0] h_rd [2][MaxCyc];
  logic          h_we [MaxCyc];

  task automatic check_eq(input string tag, input logic [DW-1:0] got,
                          input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd);
    wen[p] = w;
    addr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = wd;
  endtask

  // Check one cycle against the model, then advance the model across the edge.
  task automatic cycle();
    logic [2:0] eg, erv;
    int         idx;
    logic [AW-1:0] a;
    rd_t        r;
    #1;
    eg = 3'b000;
    if (!reset) begin
      if (m_locked && cpu_lock) begin
        eg = {req[2], 2'b00};
      end else begin
        for (int k = 1; k <= 3; k++) begin
          idx = (m_last + k) % 3;
          if (eg == 3'b000 && req[idx]) eg[idx] = 1'b1;
        end
      end
    end
    m_gnt   = eg;
    obs_gnt = gnt_a[0];
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("gnt_d%0d", d), DW'(gnt_a[d]), DW'(eg));
      check_eq($sformatf("sram_en_d%0d", d), DW'(sram_en_a[d]), DW'(e_en));
      if (e_en) check_eq($sformatf("sram_we_d%0d", d), DW'(sram_we_a[d]), DW'(e_we));
      check_eq($sformatf("sram_addr_d%0d", d), DW'(sram_addr_a[d]), DW'(e_addr));
      check_eq($sformatf("sram_wdata_d%0d", d), sram_wdata_a[d], e_wdata);
      check_eq($sformatf("stall_cnt_d%0d", d), DW'(stall_a[d]), DW'(m_stall));
      erv = 3'b000;
      if (d == 0 && rq0.size() > 0 && rq0[0].due == cyc) begin
        r = rq0.pop_front();
        erv = 3'b001 << r.own;
        e_rdata[0] = r.dat;
      end
      if (d == 1 && rq1.size() > 0 && rq1[0].due == cyc) begin
        r = rq1.pop_front();
        erv = 3'b001 << r.own;
        e_rdata[1] = r.dat;
      end
      check_eq($sformatf("rvalid_d%0d", d), DW'(rvalid_a[d]), DW'(erv));
      check_eq($sformatf("rdata_d%0d", d), rdata_a[d], e_rdata[d]);
      if (cyc < MaxCyc) begin
        h_rv[d][cyc] = rvalid_a[d];
        h_rd[d][cyc] = rdata_a[d];
      end
    end
    if (cyc < MaxCyc) h_we[cyc] = sram_we_a[0];

    if (reset) begin
      m_last = 2; m_locked = 1'b0; m_stall = '0;
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
      e_rdata[0] = '0; e_rdata[1] = '0;
      rq0.delete(); rq1.delete();
    end else begin
      e_en = (eg != 3'b000);
      e_we = 1'b0;
      if (e_en) begin
        idx     = eg[2] ? 2 : (eg[1] ? 1 : 0);
        a       = addr[idx*AW +: AW];
        e_we    = wen[idx];
        e_addr  = a;
        e_wdata = wdata[idx*DW +: DW];
        if (wen[idx]) begin
          ref_mem[a] = e_wdata;
        end else begin
          r.own = 2'(idx);
          r.dat = ref_mem[a];
          r.due = cyc + 3; rq0.push_back(r);
          r.due = cyc + 5; rq1.push_back(r);
        end
        m_last = idx;
      end
`ifdef SRAM_ARB_LOCK_EN
      if (m_locked) m_locked = cpu_lock;
      else          m_locked = eg[2] && cpu_lock;
`endif
      if (stall_clr) m_stall = '0;
      else if (((req & ~eg) != 3'b000) && (m_stall != 32'hFFFF_FFFF)) m_stall++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = 3'b000;
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [2:0] rr_exp [4];
  logic [2:0] pend;
  logic [2:0] any_rv;
  int         t;

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    reset = 1'b1; fill = 1'b1; req = '0; wen = '0; addr = '0; wdata = '0;
    cpu_lock = 1'b0; stall_clr = 1'b0;
    n_vec = 0; n_err = 0; cyc = 0; m_last = 2; m_locked = 1'b0; m_stall = '0;
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    e_rdata[0] = '0; e_rdata[1] = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
    @(posedge clk);
    #1;
    fill = 1'b0;

    // Grant held low during reset even with all ports requesting.
    req = 3'b111;
    cycle();
    check_eq("reset_gnt_low", DW'(obs_gnt), DW'(3'b000));
    reset = 1'b0;
    idle(1);

    // Round-robin rotation and stall counting with all ports reading.
    req = 3'b111; wen = 3'b000;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_eq("rr_gnt_seq", DW'(obs_gnt), DW'(rr_exp[k]));
      check_eq("rr_stall_seq", DW'(stall_a[0]), DW'(k + 1));
    end
    idle(8);

    // Port 1 read return timing for both latencies; rdata held afterwards.
    set_port(0, 1'b1, 8'h05, 72'hAB_0123456789ABCDEF);
    req = 3'b001;
    cycle();
    set_port(1, 1'b0, 8'h05, '0);
    req = 3'b010; t = cyc;
    cycle();
    idle(8);
    check_eq("p1_rv_early", DW'(h_rv[0][t+2]), DW'(3'b000));
    check_eq("p1_rv_lat1", DW'(h_rv[0][t+3]), DW'(3'b010));
    check_eq("p1_rd_lat1", h_rd[0][t+3], 72'hAB_0123456789ABCDEF);
    check_eq("p1_rv_after", DW'(h_rv[0][t+4]), DW'(3'b000));
    check_eq("p1_rd_held", h_rd[0][t+6], 72'hAB_0123456789ABCDEF);
    check_eq("p1_rv_lat3", DW'(h_rv[1][t+5]), DW'(3'b010));
    check_eq("p1_rd_lat3", h_rd[1][t+5], 72'hAB_0123456789ABCDEF);

    // Write then CPU read of the same address.
    set_port(0, 1'b1, 8'h20, 72'h11);
    req = 3'b001; t = cyc;
    cycle();
    set_port(2, 1'b0, 8'h20, '0);
    req = 3'b100;
    cycle();
    idle(8);
    check_eq("raw_sram_we", DW'(h_we[t+1]), DW'(1'b1));
    check_eq("raw_cpu_rv", DW'(h_rv[0][t+4]), DW'(3'b100));
    check_eq("raw_cpu_rd", h_rd[0][t+4], 72'h11);

    // Four back-to-back reads on the latency-3 instance.
    req = 3'b010; t = cyc;
    for (int k = 0; k < 4; k++) begin
      set_port(1, 1'b0, AW'(8'h40 + k), '0);
      cycle();
    end
    idle(10);
    check_eq("b2b_rv_early", DW'(h_rv[1][t+4]), DW'(3'b000));
    for (int k = 0; k < 4; k++) begin
      check_eq("b2b_rv", DW'(h_rv[1][t+5+k]), DW'(3'b010));
      check_eq("b2b_rd", h_rd[1][t+5+k], seed_word(8'h40 + k));
    end
    check_eq("b2b_rv_late", DW'(h_rv[1][t+9]), DW'(3'b000));

    // Reset while a read is in flight drops its return.
    set_port(1, 1'b0, 8'h07, '0);
    req = 3'b010; t = cyc;
    cycle();
    req = 3'b000; reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle(8);
    any_rv = 3'b000;
    for (int c = t + 1; c <= t + 8; c++) any_rv = any_rv | h_rv[0][c] | h_rv[1][c];
    check_eq("reset_drops_read", DW'(any_rv), DW'(3'b000));
    check_eq("reset_stall_zero", DW'(stall_a[0]), DW'(0));
    req = 3'b111;
    cycle();
    check_eq("reset_first_gnt", DW'(obs_gnt), DW'(3'b001));
    idle(4);

    // CPU lock behaviour (or its absence in the default build).
    cpu_lock = 1'b1; req = 3'b100;
    cycle();
    check_eq("lock_enter_gnt", DW'(obs_gnt), DW'(3'b100));
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      cycle();
`ifdef SRAM_ARB_LOCK_EN
      check_eq("locked_gnt", DW'(obs_gnt), DW'(3'b100));
`else
      check_eq("nolock_gnt", DW'(obs_gnt), DW'(rr_exp[k]));
`endif
      check_eq("lock_stall", DW'(stall_a[0]), DW'(k + 2));
    end
    cpu_lock = 1'b0;
    cycle();
`ifdef SRAM_ARB_LOCK_EN
    check_eq("unlock_gnt", DW'(obs_gnt), DW'(3'b001));
`else
    check_eq("unlock_gnt", DW'(obs_gnt), DW'(3'b010));
`endif
    idle(4);

    // Randomised traffic: requesters hold their request until granted.
    pend = 3'b000;
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 3; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1'b1;
          set_port(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), rand_word());
        end
      end
      req = pend;
      if ($urandom_range(0, 7) == 0) cpu_lock = ~cpu_lock;
      stall_clr = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      cycle();
      pend = pend & ~m_gnt;
    end
    reset = 1'b0; stall_clr = 1'b0; cpu_lock = 1'b0;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
